// File: rtl/pipe_field.sv
`default_nettype none
// pipe_field: scrolling pipe playfield with gap insertion, scoring and
// bird collision detection; columns scroll right-to-left on each RUN tick.
module pipe_field #(
    parameter int ROWS     = 16,
    parameter int COLS     = 16,
    parameter int GAP      = 4,
    parameter int SPACING  = 6,
    parameter int BIRD_COL = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [10:1]     rnd,
    input  logic            tick,
    input  logic            start,
    input  logic [3:0]      bird_row,
    input  logic [3:0]      rd_col,
    output logic [ROWS-1:0] rd_data,
    output logic [1:0]      state,
    output logic            hit,
    output logic [7:0]      score
);

    localparam int CW = (SPACING > 1) ? $clog2(SPACING) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t          st;
    logic [ROWS-1:0] cols [COLS];
    logic [COLS-1:0] is_pipe;
    logic [CW-1:0]   count;

    logic [3:0]      v;
    logic [31:0]     gap_top;
    logic [ROWS-1:0] pipe_col;
    logic            ins_pipe;
    logic            bird_bit;
    logic            unused_rnd;

    assign unused_rnd = ^rnd[10:5];
    assign ins_pipe   = (32'(count) == 32'(SPACING - 1));
    assign state      = st;

    // Gap tops that would run off the bottom fold back up by GAP rows.
    always_comb begin
        v       = rnd[4:1];
        gap_top = (32'(v) <= 32'(ROWS - GAP)) ? 32'(v) : 32'(v) - 32'(GAP);
        for (int r = 0; r < ROWS; r++) begin
            pipe_col[r] = !((32'(r) >= gap_top) && (32'(r) < gap_top + 32'(GAP)));
        end
    end

    always_comb begin
        rd_data = '0;
        for (int c = 0; c < COLS; c++) begin
            if (32'(rd_col) == 32'(c)) rd_data = cols[c];
        end
    end

    // Rows outside the field never match, so they can never collide.
    always_comb begin
        bird_bit = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            if (32'(bird_row) == 32'(r)) bird_bit = cols[BIRD_COL][r];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st      <= S_IDLE;
            hit     <= 1'b0;
            score   <= 8'd0;
            count   <= '0;
            is_pipe <= '0;
            for (int c = 0; c < COLS; c++) cols[c] <= '0;
        end else begin
            case (st)
                S_IDLE: begin
                    if (start) st <= S_RUN;
                end
                S_RUN: begin
                    if (hit) st <= S_HALT;
                    if (bird_bit) hit <= 1'b1;
                    if (tick) begin
                        if (is_pipe[BIRD_COL] && (score != 8'hFF)) score <= score + 8'd1;
                        for (int c = 0; c < COLS - 1; c++) cols[c] <= cols[c+1];
                        cols[COLS-1] <= ins_pipe ? pipe_col : '0;
                        is_pipe      <= {ins_pipe, is_pipe[COLS-1:1]};
                        count        <= ins_pipe ? '0 : count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_field.sv
`timescale 1ns/100ps
`default_nettype none
// Randomized directed bench for pipe_field against a queue-based playfield model.
module tb_pipe_field;

    localparam int ROWS = 16, COLS = 16, GAP = 4, SPACING = 6, BIRD = 3;

    logic            clk = 1'b0;
    logic            reset, tick, start;
    logic [10:1]     rnd;
    logic [3:0]      bird_row, rd_col;
    logic [ROWS-1:0] rd_data;
    logic [1:0]      state;
    logic            hit;
    logic [7:0]      score;

    int checks = 0;
    int errors = 0;

    // Reference model: field as a queue, column 0 at the front.
    logic [ROWS-1:0] fq[$];
    bit              pq[$];
    int              m_st, m_cnt, m_score;
    bit              m_hit;

    pipe_field dut (
        .clk(clk), .reset(reset), .rnd(rnd), .tick(tick), .start(start),
        .bird_row(bird_row), .rd_col(rd_col), .rd_data(rd_data),
        .state(state), .hit(hit), .score(score)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ROWS-1:0] pipe_of(input int v);
        int g;
        g = (v <= ROWS - GAP) ? v : v - GAP;
        return ~(ROWS'((1 << GAP) - 1) << g);
    endfunction

    task automatic model_step();
        bit nh;
        bit ins;
        if (reset) begin
            fq.delete(); pq.delete();
            for (int c = 0; c < COLS; c++) begin fq.push_back('0); pq.push_back(1'b0); end
            m_st = 0; m_cnt = 0; m_score = 0; m_hit = 1'b0;
        end else if (m_st == 0) begin
            if (start) m_st = 1;
        end else if (m_st == 1) begin
            nh = m_hit;
            if (int'(bird_row) < ROWS && fq[BIRD][bird_row]) nh = 1'b1;
            if (tick) begin
                if (pq[BIRD] && m_score < 255) m_score++;
                ins = (m_cnt == SPACING - 1);
                void'(fq.pop_front()); void'(pq.pop_front());
                fq.push_back(ins ? pipe_of(int'(rnd[4:1])) : '0);
                pq.push_back(ins);
                m_cnt = ins ? 0 : m_cnt + 1;
            end
            if (m_hit) m_st = 2;
            m_hit = nh;
        end
    endtask

    function automatic logic [ROWS-1:0] read_col_nb(input int c);
        return fq[c];
    endfunction

    task automatic sweep();
        for (int c = 0; c < COLS; c++) begin
            rd_col = 4'(c);
            #0.2;
            chk($sformatf("col%0d", c), 32'(rd_data), 32'(read_col_nb(c)));
        end
    endtask

    task automatic cycle(input logic rs, input logic st_in, input logic tk, input logic [10:1] r);
        reset = rs; start = st_in; tick = tk; rnd = r;
        @(posedge clk);
        model_step();
        #1;
        chk("state", 32'(state), 32'(m_st));
        chk("hit", 32'(hit), 32'(m_hit));
        chk("score", 32'(score), 32'(m_score));
        sweep();
    endtask

    task automatic idle_cycles();
        int n;
        n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 10'($urandom));
    endtask

    // One RUN tick; rnd[4:1] is forced to ins_v only when an insertion is due.
    task automatic tick_once(input logic [3:0] ins_v);
        logic [10:1] r;
        idle_cycles();
        r = 10'($urandom);
        if (m_cnt == SPACING - 1) r[4:1] = ins_v;
        cycle(1'b0, 1'b0, 1'b1, r);
    endtask

    task automatic read_col(input int c, output logic [ROWS-1:0] d);
        rd_col = 4'(c);
        #0.2;
        d = rd_data;
    endtask

    initial begin
        logic [ROWS-1:0] d;
        int guard;
        bird_row = 4'd0; rd_col = 4'd0;
        reset = 1'b1; start = 1'b0; tick = 1'b0; rnd = '0;
        cycle(1'b1, 1'b1, 1'b1, 10'($urandom));
        cycle(1'b1, 1'b0, 1'b0, 10'($urandom));

        // Ticks in IDLE must be ignored
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1, 10'($urandom));
        cycle(1'b0, 1'b1, 1'b1, 10'($urandom));
        chk("start_run", 32'(state), 32'd1);

        // Sixth tick inserts a pipe with gap top 5
        for (int i = 0; i < 6; i++) tick_once(4'd5);
        read_col(15, d);
        chk("ins_col15", 32'(d), 32'h0000FE1F);
        read_col(14, d);
        chk("ins_col14", 32'(d), 32'd0);
        chk("ins_score", 32'(score), 32'd0);

        // Bird at row 6 sits in every gap with top 3..6
        bird_row = 4'd6;
        for (int i = 0; i < 12; i++) tick_once(4'($urandom_range(3, 6)));
        read_col(3, d);
        chk("pipe_at_c3", 32'(d), 32'h0000FE1F);
        chk("score_pre", 32'(score), 32'd0);
        tick_once(4'($urandom_range(3, 6)));
        chk("score_one", 32'(score), 32'd1);
        guard = 0;
        while (m_score < 3 && guard < 60) begin
            tick_once(4'($urandom_range(3, 6)));
            guard++;
        end
        chk("score_three", 32'(score), 32'd3);

        // Reset mid-game with a populated field
        cycle(1'b1, 1'b1, 1'b1, 10'($urandom));
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_score", 32'(score), 32'd0);

        // Gap fold: value 14 yields gap rows 10..13
        cycle(1'b0, 1'b1, 1'b0, 10'($urandom));
        bird_row = 4'd11;
        for (int i = 0; i < 6; i++) tick_once(4'd14);
        read_col(15, d);
        chk("fold_col15", 32'(d), 32'h0000C3FF);
        for (int i = 0; i < 6; i++) tick_once(4'd5);
        for (int i = 0; i < 7; i++) tick_once(4'($urandom));
        chk("fold_score", 32'(score), 32'd1);

        // Bird at row 2 meets the gap 5..8 pipe at the bird column
        bird_row = 4'd2;
        guard = 0;
        while (!m_hit && guard < 12) begin
            cycle(1'b0, 1'b0, 1'b1, 10'($urandom));
            guard++;
        end
        chk("hit_set", 32'(hit), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 10'($urandom));
        chk("halt", 32'(state), 32'd2);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1, 10'($urandom));
        chk("halt_hold", 32'(state), 32'd2);

        // Reset overrides everything in HALT
        bird_row = 4'($urandom);
        cycle(1'b1, 1'b1, 1'b1, 10'($urandom));
        chk("halt_rst", 32'(state), 32'd0);
        chk("halt_rst_hit", 32'(hit), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_field.md
PIPE_FIELD -- requirements
Module: pipe_field

Interface
REQ-001 Parameters (name, default, meaning), one per line; shall be:
- ROWS, 16, display rows.
- COLS, 16, display columns.
- GAP, 4, gap height in rows.
- SPACING, 6, ticks per pipe insertion.
- BIRD_COL, 3, bird column index.
REQ-002 Ports (name, direction, width, meaning), one per line; shall be:
- clk, input, 1, clock.
- reset, input, 1, synchronous, active-high.
- rnd, input, 10 ([10:1]), random word from the upstream 10-bit LFSR.
- tick, input, 1, one-cycle scroll pulse.
- start, input, 1, begin game.
- bird_row, input, 4, bird row, 0 = top.
- rd_col, input, 4, column select for rd_data.
- rd_data, output, ROWS, occupancy of column rd_col; bit r = 1 means pipe at row r.
- state, output, 2, 0 = IDLE, 1 = RUN, 2 = HALT.
- hit, output, 1, registered collision flag.
- score, output, 8, pipes passed.

Function
REQ-003 Storage: COLS column words of ROWS bits, plus one is_pipe flag per column; column 0 is leftmost.
REQ-004 rd_data shall be combinational from the column store; rd_col >= COLS shall return all zeros.
REQ-005 State machine transitions:
- IDLE -> RUN on start = 1.
- RUN -> HALT on the cycle after hit is set.
- HALT holds until reset.
- start is ignored in RUN and HALT.
REQ-006 Gating: tick shall be ignored in IDLE and HALT; no scroll, no counting, no score change.
REQ-007 Scroll: each RUN tick shifts every column i <= column i+1 for i < COLS-1, carrying is_pipe; column COLS-1 receives the inserted column.
REQ-008 Spacing counter (0..SPACING-1, reset 0):
- On a RUN tick at count SPACING-1, insert a pipe column and set count to 0.
- Otherwise insert an all-zero column and increment count.
REQ-009 Gap top g shall be computed from v = rnd[4:1]:
- g = v if v <= ROWS-GAP.
- g = v - GAP otherwise.
- With defaults: 13->9, 14->10, 15->11.
REQ-010 Pipe column: rows g..g+GAP-1 shall be 0; all other rows 1; is_pipe = 1.
REQ-011 rnd shall be sampled only on the inserting tick cycle.
REQ-012 Score:
- On a RUN tick, if is_pipe of column BIRD_COL before the shift is 1, score increments by 1.
- Score saturates at 255.
REQ-013 Collision: in RUN, hit is set on the next clock when bit bird_row of column BIRD_COL (current contents) is 1; hit is sticky until reset.
REQ-014 Tick and collision in the same cycle:
- The scroll and score update shall complete.
- hit shall use pre-shift contents.
REQ-015 bird_row >= ROWS shall never cause a hit.
REQ-016 Latency: every state, storage and score update takes effect on the clock edge following the qualifying input.
REQ-017 start and tick asserted together in IDLE: enter RUN; that tick shall be ignored.

Reset
REQ-018 On reset = 1 at a clock edge, the following values shall be loaded:
- all columns 0 and all is_pipe 0;
- count 0;
- state IDLE;
- hit 0;
- score 0.
REQ-019 Reset shall override start, tick and collision in the same cycle, including mid-game and in HALT.
REQ-020 Outputs after reset: rd_data shall read 0 for every column; score = 0; state = 0.

Verification
REQ-021 Reset mid-RUN with score 3 and populated field -> next cycle state 0, score 0, every rd_data 0, hit 0.
REQ-022 Insertion timing: start, then 6 ticks with rnd[4:1] = 5, bird_row = 0 -> after 6th tick:
- column 15 = 16'b1111_1110_0001_1111 (rows 5..8 clear);
- columns 0..14 = 0;
- score 0.
REQ-023 Gap fold: rnd[4:1] = 14 at the insertion tick -> column 15 shall have rows 10..13 zero and all other rows one.
REQ-024 Score: after insertion, 12 more ticks with bird_row placed in the gap -> pipe reaches column 3 on tick 12; score = 1 after tick 13.
REQ-025 Collision: pipe at column 3 with gap rows 5..8 and bird_row = 2 -> hit = 1 next cycle, then state HALT; further ticks leave columns and score unchanged.
REQ-026 Gating: 10 ticks in IDLE -> columns unchanged and count unchanged; a start/tick coincidence shall not scroll.
